// File: rtl/instruction_sequencer_pkg.sv
// Shared CPU definitions: command and condition codes, argument type bits,
// register and attention-flag indices, instruction field positions and the
// sequencer FSM state encoding.
package instruction_sequencer_pkg;

  // Command codes carried in bits [31:29]; the all-zero word is a NOP.
  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_MOV = 3'd1;
  localparam logic [2:0] CMD_ACC = 3'd2;
  localparam logic [2:0] CMD_JMP = 3'd3;
  localparam logic [2:0] CMD_ATC = 3'd4;

  // Jump condition codes carried in the op field.
  localparam logic [2:0] COND_UNC = 3'd0;
  localparam logic [2:0] COND_EQ  = 3'd1;
  localparam logic [2:0] COND_SLE = 3'd2;

  // Argument type selector: register read or immediate number.
  localparam logic ARG_REG = 1'b0;
  localparam logic ARG_NUM = 1'b1;

  // Attention flag index for the push button.
  localparam logic [2:0] ATC_PUSH = 3'd2;

  // Register addresses used in argument fields.
  localparam logic [7:0] REG_STACK0 = 8'h01;
  localparam logic [7:0] REG_DINP   = 8'h05;
  localparam logic [7:0] REG_SIZE   = 8'h06;

  // Instruction field bit positions.
  localparam int CMD_MSB       = 31;
  localparam int CMD_LSB       = 29;
  localparam int OP_MSB        = 28;
  localparam int OP_LSB        = 26;
  localparam int ARG1_TYPE_BIT = 25;
  localparam int ARG1_MSB      = 24;
  localparam int ARG1_LSB      = 17;
  localparam int ARG2_TYPE_BIT = 16;
  localparam int ARG2_MSB      = 15;
  localparam int ARG2_LSB      = 8;
  localparam int ADDR_MSB      = 7;
  localparam int ADDR_LSB      = 0;

  // Sequencer FSM states.
  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/instruction_sequencer_branch_condition_unit.sv
// Combinational jump condition evaluator: (cond, a, b) -> taken.
// SLE compares a and b as 8-bit two's complement values; unknown
// condition codes are never taken.
module branch_condition_unit
  import instruction_sequencer_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       taken
);

  // Decode the condition code into a taken/not-taken decision.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_UNC: taken = 1'b1;
      COND_EQ:  taken = (a == b);
      COND_SLE: taken = ($signed(a) <= $signed(b));
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Two-state (FETCH/EXEC) instruction sequencer. Owns the PC, latches the
// ROM word into the IR during FETCH and, during EXEC, either strobes the
// datapath (MOV/ACC) or resolves JMP/ATC control flow locally.
// Optional build macro SEQ_SINGLE_STEP_EN adds step_req/step_wait: FETCH
// then stalls until step_req is sampled high.
// Handshake: exec_valid is a one-cycle strobe with no back-pressure; the
// exec_* fields are meaningful only while exec_valid is high and otherwise
// keep the last latched IR contents. atc_clear is a one-cycle one-hot pulse.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic [PC_WIDTH-1:0] address,
  input  logic [31:0]         instruction,
  input  logic [7:0]          arg1_value,
  input  logic [7:0]          arg2_value,
  input  logic [7:0]          atc_flags,
  output logic [7:0]          atc_clear,
  output logic                exec_valid,
  output logic [2:0]          exec_cmd,
  output logic [2:0]          exec_op,
  output logic                exec_arg1_type,
  output logic [7:0]          exec_arg1,
  output logic                exec_arg2_type,
  output logic [7:0]          exec_arg2,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                step_req,
  output logic                step_wait,
`endif
  output seq_state_e          state_dbg
);

  seq_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic                advance;
  logic                jmp_taken;
  logic [2:0]          ir_cmd;
  logic [2:0]          ir_op;
  logic [PC_WIDTH-1:0] ir_addr;
  logic [PC_WIDTH-1:0] pc_inc;

  assign ir_cmd  = ir_q[CMD_MSB:CMD_LSB];
  assign ir_op   = ir_q[OP_MSB:OP_LSB];
  assign ir_addr = PC_WIDTH'(ir_q[ADDR_MSB:ADDR_LSB]);
  assign pc_inc  = pc_q + PC_WIDTH'(1);

`ifdef SEQ_SINGLE_STEP_EN
  assign advance   = step_req;
  assign step_wait = (state_q == S_FETCH);
`else
  assign advance   = 1'b1;
`endif

  assign address        = pc_q;
  assign state_dbg      = state_q;
  assign exec_cmd       = ir_cmd;
  assign exec_op        = ir_op;
  assign exec_arg1_type = ir_q[ARG1_TYPE_BIT];
  assign exec_arg1      = ir_q[ARG1_MSB:ARG1_LSB];
  assign exec_arg2_type = ir_q[ARG2_TYPE_BIT];
  assign exec_arg2      = ir_q[ARG2_MSB:ARG2_LSB];

  branch_condition_unit u_branch (
    .cond  (ir_op),
    .a     (arg1_value),
    .b     (arg2_value),
    .taken (jmp_taken)
  );

  // State, PC and IR registers; reset discards any in-flight instruction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, next-PC and strobe decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    exec_valid = 1'b0;
    atc_clear  = '0;
    case (state_q)
      S_FETCH: begin
        if (advance) begin
          ir_d    = instruction;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (ir_cmd)
          CMD_MOV, CMD_ACC: exec_valid = 1'b1;
          CMD_JMP: begin
            if (jmp_taken) pc_d = ir_addr;
          end
          CMD_ATC: begin
            if (atc_flags[ir_op]) begin
              pc_d      = ir_addr;
              atc_clear = 8'b1 << ir_op;
            end
          end
          default: ;
        endcase
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: table-driven single
// instruction vectors checked through an expected-result queue, plus hand
// sequences for reset, mid-instruction reset and single stepping.
module tb_instruction_sequencer;
  import instruction_sequencer_pkg::*;

  localparam int W = 45;

  // Clock/reset block
  logic        clock;
  logic        reset_n;
  logic [7:0]  address;
  logic [31:0] instruction;
  logic [7:0]  arg1_value, arg2_value, atc_flags, atc_clear;
  logic        exec_valid, exec_arg1_type, exec_arg2_type;
  logic [2:0]  exec_cmd, exec_op;
  logic [7:0]  exec_arg1, exec_arg2;
  seq_state_e  state_dbg;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step_req;
  logic        step_wait;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] rom [256];
  assign instruction = rom[address];

  instruction_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .address        (address),
    .instruction    (instruction),
    .arg1_value     (arg1_value),
    .arg2_value     (arg2_value),
    .atc_flags      (atc_flags),
    .atc_clear      (atc_clear),
    .exec_valid     (exec_valid),
    .exec_cmd       (exec_cmd),
    .exec_op        (exec_op),
    .exec_arg1_type (exec_arg1_type),
    .exec_arg1      (exec_arg1),
    .exec_arg2_type (exec_arg2_type),
    .exec_arg2      (exec_arg2),
`ifdef SEQ_SINGLE_STEP_EN
    .step_req       (step_req),
    .step_wait      (step_wait),
`endif
    .state_dbg      (state_dbg)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [2:0] cmd, input logic [2:0] op,
                                      input logic t1, input logic [7:0] a1,
                                      input logic t2, input logic [7:0] a2,
                                      input logic [7:0] addr);
    return {cmd, op, t1, a1, t2, a2, addr};
  endfunction

  // Scoreboard: expected {valid, cmd, arg1, arg2, clear, next_addr,
  // valid_after, clear_after} per monitored instruction.
  logic [W-1:0] exp_q[$];
  logic         mon_en = 1'b0;
  logic [7:0]   mon_pc = 8'h00;
  logic         pend = 1'b0;
  logic [27:0]  cap;
  int           vec_id = 0;

  always @(negedge clock) begin
    logic [W-1:0] got, exp;
    if (pend) begin
      pend   = 1'b0;
      mon_en = 1'b0;
      got = {cap, address, exec_valid, atc_clear};
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        if (!exp[44]) begin
          got[43:25] = '0;
          exp[43:25] = '0;
        end
        check($sformatf("vec%0d", vec_id), 64'(got), 64'(exp));
      end
    end else if (mon_en && reset_n && state_dbg == S_EXEC && address == mon_pc) begin
      cap  = {exec_valid, exec_cmd, exec_arg1, exec_arg2, atc_clear};
      pend = 1'b1;
    end
  end

  // Driver tasks
  task automatic clear_rom();
    for (int k = 0; k < 256; k++) rom[k] = 32'h0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
    logic [7:0]  a1, a2, flags;
    logic        ev;
    logic [2:0]  cmd;
    logic [7:0]  ea1, ea2, clr, nxt;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkv(input logic [7:0] pc, input logic [31:0] instr,
                               input logic [7:0] a1, input logic [7:0] a2,
                               input logic [7:0] flags, input logic ev,
                               input logic [2:0] cmd, input logic [7:0] ea1,
                               input logic [7:0] ea2, input logic [7:0] clr,
                               input logic [7:0] nxt);
    vec_t v;
    v.pc = pc; v.instr = instr; v.a1 = a1; v.a2 = a2; v.flags = flags;
    v.ev = ev; v.cmd = cmd; v.ea1 = ea1; v.ea2 = ea2; v.clr = clr; v.nxt = nxt;
    return v;
  endfunction

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    vec_id = i;
    clear_rom();
    if (v.pc != 8'h00) rom[0] = ins(CMD_JMP, COND_UNC, ARG_NUM, 8'h00, ARG_NUM, 8'h00, v.pc);
    rom[v.pc]  = v.instr;
    arg1_value = v.a1;
    arg2_value = v.a2;
    atc_flags  = v.flags;
    mon_pc     = v.pc;
    exp_q.push_back({v.ev, v.cmd, v.ea1, v.ea2, v.clr, v.nxt, 1'b0, 8'h00});
    do_reset();
    mon_en = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clock);
    if (exp_q.size() != 0) begin
      check($sformatf("vec%0d_timeout", i), 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      mon_en = 1'b0;
      pend   = 1'b0;
    end
  endtask

  logic [31:0] atc_push5, mov_w, acc_w, jeq_w, jsle_w;

  initial begin
    int ok;
    reset_n    = 1'b0;
    arg1_value = '0;
    arg2_value = '0;
    atc_flags  = '0;
`ifdef SEQ_SINGLE_STEP_EN
    step_req   = 1'b1;
`endif
    clear_rom();

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_addr", 64'(address), 64'd0);
    check("rst_valid", 64'(exec_valid), 64'd0);
    check("rst_clear", 64'(atc_clear), 64'd0);
    check("rst_fields", 64'({exec_cmd, exec_op, exec_arg1, exec_arg2}), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(S_FETCH));

    atc_push5 = ins(CMD_ATC, ATC_PUSH, ARG_NUM, 8'h00, ARG_NUM, 8'h00, 8'd5);
    mov_w     = ins(CMD_MOV, 3'd0, ARG_REG, REG_DINP, ARG_REG, REG_STACK0, 8'h00);
    acc_w     = ins(CMD_ACC, 3'd0, ARG_NUM, 8'h07, ARG_REG, REG_STACK0, 8'h00);
    jeq_w     = ins(CMD_JMP, COND_EQ, ARG_REG, REG_SIZE, ARG_NUM, 8'h00, 8'd20);
    jsle_w    = ins(CMD_JMP, COND_SLE, ARG_REG, 8'h02, ARG_NUM, 8'h02, 8'd58);

    vecs[0]  = mkv(8'd0,   atc_push5, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd1);
    vecs[1]  = mkv(8'd0,   atc_push5, 8'h00, 8'h00, 8'h04, 1'b0, 3'd0, 8'h00, 8'h00, 8'h04, 8'd5);
    vecs[2]  = mkv(8'd0,   atc_push5, 8'h00, 8'h00, 8'hFB, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd1);
    vecs[3]  = mkv(8'd8,   mov_w,     8'h00, 8'h00, 8'h00, 1'b1, CMD_MOV, REG_DINP, REG_STACK0, 8'h00, 8'd9);
    vecs[4]  = mkv(8'd8,   acc_w,     8'h00, 8'h00, 8'hFF, 1'b1, CMD_ACC, 8'h07, REG_STACK0, 8'h00, 8'd9);
    vecs[5]  = mkv(8'd13,  jeq_w,     8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd20);
    vecs[6]  = mkv(8'd13,  jeq_w,     8'h03, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd14);
    vecs[7]  = mkv(8'd54,  jsle_w,    8'hFF, 8'h02, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd58);
    vecs[8]  = mkv(8'd54,  jsle_w,    8'h03, 8'h02, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd55);
    vecs[9]  = mkv(8'd54,  jsle_w,    8'h80, 8'h80, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd58);
    vecs[10] = mkv(8'd54,  jsle_w,    8'h7F, 8'h80, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd55);
    vecs[11] = mkv(8'd30,  ins(CMD_JMP, COND_UNC, ARG_NUM, 8'h00, ARG_NUM, 8'h00, 8'd30),
                   8'h01, 8'h02, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd30);
    vecs[12] = mkv(8'd30,  ins(CMD_JMP, 3'd5, ARG_NUM, 8'h00, ARG_NUM, 8'h00, 8'd40),
                   8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd31);
    vecs[13] = mkv(8'd255, 32'h0,     8'h00, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd0);
    vecs[14] = mkv(8'd100, ins(3'd7, 3'd3, ARG_REG, 8'h11, ARG_REG, 8'h22, 8'd9),
                   8'h00, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd101);
    vecs[15] = mkv(8'd0,   ins(CMD_ATC, 3'd7, ARG_NUM, 8'h00, ARG_NUM, 8'h00, 8'd9),
                   8'h00, 8'h00, 8'h80, 1'b0, 3'd0, 8'h00, 8'h00, 8'h80, 8'd9);

    for (int i = 0; i < 16; i++) run_vec(i);

    // Reset asserted during EXEC of a MOV discards it
    clear_rom();
    rom[0] = ins(CMD_JMP, COND_UNC, ARG_NUM, 8'h00, ARG_NUM, 8'h00, 8'd8);
    rom[8] = mov_w;
    do_reset();
    ok = 0;
    for (int c = 0; c < 20 && ok == 0; c++) begin
      @(negedge clock);
      if (state_dbg == S_FETCH && address == 8'd8) ok = 1;
    end
    check("midrst_reach", 64'(ok), 64'd1);
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(negedge clock);
    check("midrst_valid", 64'(exec_valid), 64'd0);
    check("midrst_addr", 64'(address), 64'd0);
    check("midrst_ir", 64'({exec_cmd, exec_arg1, exec_arg2}), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("midrst_restart", 64'({state_dbg, address}), 64'({S_EXEC, 8'd0}));

`ifdef SEQ_SINGLE_STEP_EN
    // Single stepping: stall without step_req, then three single pulses
    clear_rom();
    step_req = 1'b0;
    do_reset();
    repeat (5) @(negedge clock);
    check("step_hold_addr", 64'(address), 64'd0);
    check("step_wait", 64'(step_wait), 64'd1);
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      @(negedge clock);
      step_req = 1'b0;
      repeat (3) @(negedge clock);
    end
    check("step_three", 64'(address), 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Consumer of the 32-bit instruction word produced by instruction_memory.
- Owns the 8-bit program counter (PC) and drives it onto the instruction_memory address input. Registers the returned word and splits it into fields.
- Resolves JMP and ATC control flow locally. Issues MOV and ACC to the datapath as a one-cycle execute strobe with decoded fields.
- Sits between instruction_memory and the CPU datapath/register file inside the cpu top level.

Parameters:
- PC_WIDTH, 8, program counter and address width (256 words).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  out  8  instruction_memory address; always equal to PC.
- instruction  in  32  instruction_memory data (combinational ROM).
- arg1_value  in  8  datapath-resolved value of decoded arg1 (register read or immediate).
- arg2_value  in  8  datapath-resolved value of decoded arg2.
- atc_flags  in  8  sticky attention flags (buttons, overflow), indexed by the atc bit field.
- atc_clear  out  8  one-hot, one-cycle pulse clearing the serviced attention flag.
- exec_valid  out  1  one-cycle strobe: datapath executes the decoded MOV/ACC.
- exec_cmd  out  3  decoded command field.
- exec_op  out  3  decoded op/condition field.
- exec_arg1_type  out  1  `REG/`NUM selector for arg1.
- exec_arg1  out  8  arg1 field.
- exec_arg2_type  out  1  selector for arg2.
- exec_arg2  out  8  arg2 field (destination register for MOV/ACC).

Behaviour:
- Instruction fields: [31:29] cmd, [28:26] op/cond/atc bit, [25] arg1 type, [24:17] arg1, [16] arg2 type, [15:8] arg2, [7:0] jump address.
- Command and condition codes come from the shared definitions header: `MOV, `ACC, `JMP, `ATC, `UNC, `EQ, `SLE. The all-zero word is NOP.
- FSM has two states: FETCH and EXEC. Each instruction takes 2 cycles.
- FETCH: address = PC. The instruction word is latched into the IR. Next state is EXEC. exec_valid = 0.
- EXEC for MOV/ACC: exec_valid = 1 for this cycle only, with exec_* driven from the IR. PC <= PC+1. Next state is FETCH.
- EXEC for JMP: evaluate the condition on arg1_value and arg2_value.
  - `UNC: always taken.
  - `EQ: taken when a == b.
  - `SLE: taken when signed a <= b (8-bit two's complement).
  - Any other cond code: not taken.
  - Taken: PC <= addr. Not taken: PC <= PC+1.
- EXEC for ATC: if atc_flags[op] is set, then PC <= addr and atc_clear[op] pulses for 1 cycle. Otherwise PC <= PC+1 and atc_clear = 0.
- EXEC for NOP or an undefined cmd: PC <= PC+1 with no strobes.
- PC increments wrap from 255 to 0.
- A jump to the current address is legal, e.g. the wait loop spinning on jmp(0).
- If an atc_flags bit rises in the same cycle it is sampled, it is serviced. If it rises one cycle later, it is seen on the next ATC.
- Reset values: PC = RESET_PC, state = FETCH, IR = 0, exec_valid = 0, atc_clear = 0, all exec_* = 0.
- A reset asserted mid-instruction discards the IR. No strobe fires. Fetch restarts at RESET_PC after release.
- exec_* hold their last decoded value outside EXEC. Only exec_valid qualifies them.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined, the block adds input step_req (1 bit) and output step_wait (1 bit).
  - The FSM stalls in FETCH, with step_wait = 1, until step_req is sampled high. It then completes exactly one instruction.
  - step_req held high for multiple cycles advances one instruction per FETCH.
- When undefined, neither port exists and FETCH always advances.

Decomposition:
- Shared package/header (cpu definitions) holds:
  - command codes, condition codes and the `REG/`NUM type bits;
  - field bit positions as named constants;
  - FSM state encodings S_FETCH and S_EXEC.
- One natural sub-module: branch_condition_unit. It is combinational: (cond, a, b) -> taken. It is reusable by the datapath flags logic.

Test Plan:
- Reset release with ROM word 0 = atc(`PUSH,5) and atc_flags = 0: address 0 -> 1 after two cycles. No atc_clear or exec_valid pulses.
- atc_flags[`PUSH] = 1 at PC 0: next FETCH address = 5, atc_clear = one-hot of `PUSH for exactly 1 cycle.
- MOV at PC 8 (`DINP -> `STACK0): exec_valid high 1 cycle with exec_cmd = `MOV, exec_arg1 = `DINP, exec_arg2 = `STACK0. Next address = 9.
- jmp_if_size(0,20) at PC 13:
  - arg1_value = 0, arg2_value = 0 -> next address 20.
  - arg1_value = 3 -> next address 14.
- SLE jump at PC 54: arg2_value = 2, arg1_value = 0xFF (-1) -> taken to 58. arg1_value = 3 -> falls to 55.
- Additional stepping and reset checks:
  - PC = 255 with NOP -> wraps to 0.
  - reset_n pulsed low during EXEC of a MOV -> no exec_valid, address returns to 0.
  - With SEQ_SINGLE_STEP_EN, three step_req pulses -> exactly three instructions retired.
